// File: rtl/mem_pipe_chain.sv
// mem_pipe_chain: DEPTH-stage memory pipeline with combinational operand-forwarding
// queries; a halt reaching the final stage kills younger entries and freezes the chain.
module mem_pipe_chain #(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32,
    parameter int NUM_Q = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  stall,
    input  logic                  in_valid,
    input  logic [4:0]            in_opcode,
    input  logic [4:0]            in_tgt_1,
    input  logic [4:0]            in_tgt_2,
    input  logic [XLEN-1:0]       in_result_1,
    input  logic [XLEN-1:0]       in_result_2,
    input  logic [XLEN-1:0]       in_addr,
    input  logic                  in_is_load,
    input  logic                  in_is_store,
    input  logic                  in_halt,
    output logic                  out_valid,
    output logic [4:0]            out_opcode,
    output logic [4:0]            out_tgt_1,
    output logic [4:0]            out_tgt_2,
    output logic [XLEN-1:0]       out_result_1,
    output logic [XLEN-1:0]       out_result_2,
    output logic [XLEN-1:0]       out_addr,
    output logic                  out_is_load,
    output logic                  out_is_store,
    output logic                  out_halt,
    input  logic [NUM_Q*5-1:0]    q_src,
    output logic [NUM_Q-1:0]      q_hit,
    output logic [NUM_Q*XLEN-1:0] q_data,
    output logic [NUM_Q-1:0]      q_load_pend,
    output logic [3:0]            occupancy
);

    logic [DEPTH-1:0] valid_reg;
    logic [DEPTH-1:0] load_reg;
    logic [DEPTH-1:0] store_reg;
    logic [DEPTH-1:0] halt_reg;
    logic [4:0]       opcode_reg [DEPTH];
    logic [4:0]       tgt1_reg   [DEPTH];
    logic [4:0]       tgt2_reg   [DEPTH];
    logic [XLEN-1:0]  res1_reg   [DEPTH];
    logic [XLEN-1:0]  res2_reg   [DEPTH];
    logic [XLEN-1:0]  addr_reg   [DEPTH];
    logic             frozen_reg;
    logic [3:0]       occupancy_next;

    assign out_halt = valid_reg[DEPTH-1] & halt_reg[DEPTH-1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frozen_reg <= 1'b0;
            valid_reg  <= '0;
            load_reg   <= '0;
            store_reg  <= '0;
            halt_reg   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                opcode_reg[i] <= '0;
                tgt1_reg[i]   <= '0;
                tgt2_reg[i]   <= '0;
                res1_reg[i]   <= '0;
                res2_reg[i]   <= '0;
                addr_reg[i]   <= '0;
            end
        end else if (!stall && !frozen_reg) begin
            if (out_halt) begin
                // Halt retires in place: younger entries are squashed, the halt itself stays visible.
                for (int i = 0; i < DEPTH - 1; i++) valid_reg[i] <= 1'b0;
                frozen_reg <= 1'b1;
            end else begin
                valid_reg[0]  <= in_valid;
                load_reg[0]   <= in_is_load;
                store_reg[0]  <= in_is_store;
                halt_reg[0]   <= in_halt;
                opcode_reg[0] <= in_opcode;
                tgt1_reg[0]   <= in_tgt_1;
                tgt2_reg[0]   <= in_tgt_2;
                res1_reg[0]   <= in_result_1;
                res2_reg[0]   <= in_result_2;
                addr_reg[0]   <= in_addr;
                for (int i = 1; i < DEPTH; i++) begin
                    valid_reg[i]  <= valid_reg[i-1];
                    load_reg[i]   <= load_reg[i-1];
                    store_reg[i]  <= store_reg[i-1];
                    halt_reg[i]   <= halt_reg[i-1];
                    opcode_reg[i] <= opcode_reg[i-1];
                    tgt1_reg[i]   <= tgt1_reg[i-1];
                    tgt2_reg[i]   <= tgt2_reg[i-1];
                    res1_reg[i]   <= res1_reg[i-1];
                    res2_reg[i]   <= res2_reg[i-1];
                    addr_reg[i]   <= addr_reg[i-1];
                end
            end
        end
    end

    assign out_valid    = valid_reg[DEPTH-1];
    assign out_opcode   = opcode_reg[DEPTH-1];
    assign out_tgt_1    = tgt1_reg[DEPTH-1];
    assign out_tgt_2    = tgt2_reg[DEPTH-1];
    assign out_result_1 = res1_reg[DEPTH-1];
    assign out_result_2 = res2_reg[DEPTH-1];
    assign out_addr     = addr_reg[DEPTH-1];
    assign out_is_load  = load_reg[DEPTH-1];
    assign out_is_store = store_reg[DEPTH-1];

    always_comb begin
        occupancy_next = '0;
        for (int i = 0; i < DEPTH; i++) occupancy_next = occupancy_next + {3'b000, valid_reg[i]};
    end
    assign occupancy = occupancy_next;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_Q; gi++) begin : g_query
            logic [4:0]      src;
            logic            hit_next;
            logic [XLEN-1:0] data_next;
            logic            pend_next;

            assign src = q_src[gi*5 +: 5];

            // Scan oldest to youngest so later (younger, tgt_1) matches override earlier ones.
            always_comb begin
                hit_next  = 1'b0;
                data_next = '0;
                pend_next = 1'b0;
                for (int i = DEPTH - 1; i >= 0; i--) begin
                    if (valid_reg[i] && (src != 5'd0) && (tgt2_reg[i] == src)) begin
                        hit_next  = 1'b1;
                        data_next = res2_reg[i];
                        pend_next = load_reg[i];
                    end
                    if (valid_reg[i] && (src != 5'd0) && (tgt1_reg[i] == src)) begin
                        hit_next  = 1'b1;
                        data_next = res1_reg[i];
                        pend_next = load_reg[i];
                    end
                end
            end

            assign q_hit[gi]               = hit_next;
            assign q_data[gi*XLEN +: XLEN] = data_next;
            assign q_load_pend[gi]         = pend_next;
        end
    endgenerate

endmodule

// File: tb/tb_mem_pipe_chain.sv
// Testbench for mem_pipe_chain (DEPTH=4): queue-based reference pipeline with
// first-match forwarding search, directed scenarios plus randomized traffic.
module tb_mem_pipe_chain;
    localparam int D  = 4;
    localparam int XL = 32;
    localparam int NQ = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst_n = 1'b1;
    logic            stall = 1'b0;
    logic            in_valid = 1'b0;
    logic [4:0]      in_opcode = '0, in_tgt_1 = '0, in_tgt_2 = '0;
    logic [XL-1:0]   in_result_1 = '0, in_result_2 = '0, in_addr = '0;
    logic            in_is_load = 1'b0, in_is_store = 1'b0, in_halt = 1'b0;
    logic            out_valid, out_is_load, out_is_store, out_halt;
    logic [4:0]      out_opcode, out_tgt_1, out_tgt_2;
    logic [XL-1:0]   out_result_1, out_result_2, out_addr;
    logic [NQ*5-1:0] q_src = '0;
    logic [NQ-1:0]   q_hit, q_load_pend;
    logic [NQ*XL-1:0] q_data;
    logic [3:0]      occupancy;

    mem_pipe_chain #(.DEPTH(D), .XLEN(XL), .NUM_Q(NQ)) dut (
        .clk(clk), .rst_n(rst_n), .stall(stall),
        .in_valid(in_valid), .in_opcode(in_opcode), .in_tgt_1(in_tgt_1), .in_tgt_2(in_tgt_2),
        .in_result_1(in_result_1), .in_result_2(in_result_2), .in_addr(in_addr),
        .in_is_load(in_is_load), .in_is_store(in_is_store), .in_halt(in_halt),
        .out_valid(out_valid), .out_opcode(out_opcode), .out_tgt_1(out_tgt_1), .out_tgt_2(out_tgt_2),
        .out_result_1(out_result_1), .out_result_2(out_result_2), .out_addr(out_addr),
        .out_is_load(out_is_load), .out_is_store(out_is_store), .out_halt(out_halt),
        .q_src(q_src), .q_hit(q_hit), .q_data(q_data), .q_load_pend(q_load_pend),
        .occupancy(occupancy)
    );

    typedef struct {
        bit        v;
        bit [4:0]  op, t1, t2;
        bit [31:0] r1, r2, addr;
        bit        ld, st, hl;
    } ent_t;

    ent_t pq[$];   // index 0 = youngest stage
    bit   m_frozen;
    int   checks = 0;
    int   errors = 0;

    function automatic ent_t blank();
        ent_t e;
        e.v = 0; e.op = 0; e.t1 = 0; e.t2 = 0; e.r1 = 0; e.r2 = 0; e.addr = 0;
        e.ld = 0; e.st = 0; e.hl = 0;
        return e;
    endfunction

    function automatic ent_t rand_ent(bit v);
        ent_t e;
        e.v = v;
        e.op = 5'($urandom_range(0, 31));
        e.t1 = 5'($urandom_range(0, 7));
        e.t2 = 5'($urandom_range(0, 7));
        e.r1 = $urandom; e.r2 = $urandom; e.addr = $urandom;
        e.ld = 1'($urandom_range(0, 1));
        e.st = 1'($urandom_range(0, 1));
        e.hl = 0;
        return e;
    endfunction

    task automatic drive(input ent_t e);
        in_valid = e.v; in_opcode = e.op; in_tgt_1 = e.t1; in_tgt_2 = e.t2;
        in_result_1 = e.r1; in_result_2 = e.r2; in_addr = e.addr;
        in_is_load = e.ld; in_is_store = e.st; in_halt = e.hl;
    endtask

    function automatic ent_t cur_in();
        ent_t e;
        e.v = in_valid; e.op = in_opcode; e.t1 = in_tgt_1; e.t2 = in_tgt_2;
        e.r1 = in_result_1; e.r2 = in_result_2; e.addr = in_addr;
        e.ld = in_is_load; e.st = in_is_store; e.hl = in_halt;
        return e;
    endfunction

    task automatic model_reset();
        pq.delete();
        for (int i = 0; i < D; i++) pq.push_back(blank());
        m_frozen = 0;
    endtask

    function automatic int m_occ();
        int n = 0;
        foreach (pq[i]) if (pq[i].v) n++;
        return n;
    endfunction

    // Youngest valid entry whose tgt_1 or tgt_2 names the source wins; tgt_1 first.
    function automatic void mq(input bit [4:0] s, output bit h, output bit [31:0] d, output bit p);
        h = 0; d = 0; p = 0;
        if (s != 0) begin
            foreach (pq[i]) begin
                if (!h && pq[i].v) begin
                    if (pq[i].t1 == s) begin h = 1; d = pq[i].r1; p = pq[i].ld; end
                    else if (pq[i].t2 == s) begin h = 1; d = pq[i].r2; p = pq[i].ld; end
                end
            end
        end
    endfunction

    task automatic tick();
        ent_t e;
        bit   s;
        e = cur_in();
        s = stall;
        @(posedge clk);
        if (!s && !m_frozen) begin
            if (pq[D-1].v && pq[D-1].hl) begin
                for (int i = 0; i < D - 1; i++) begin
                    ent_t t;
                    t = pq[i]; t.v = 0; pq[i] = t;
                end
                m_frozen = 1;
            end else begin
                pq.push_front(e);
                void'(pq.pop_back());
            end
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        stall = 1'b0;
        drive(blank());
        q_src = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        drive(rand_ent(1));
        q_src = {5'd3, 5'd5};
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %0b want 0", out_valid); end
        checks++; if (out_halt !== 1'b0) begin errors++; $display("FAIL reset_out_halt got %0b want 0", out_halt); end
        checks++; if (occupancy !== 4'd0) begin errors++; $display("FAIL reset_occupancy got %0d want 0", occupancy); end
        checks++; if (q_hit !== 2'b00) begin errors++; $display("FAIL reset_q_hit got %b want 00", q_hit); end
        checks++; if (q_data !== '0) begin errors++; $display("FAIL reset_q_data got %h want 0", q_data); end
        checks++; if (q_load_pend !== 2'b00) begin errors++; $display("FAIL reset_q_load_pend got %b want 00", q_load_pend); end
        checks++; if (out_result_1 !== 32'd0 || out_addr !== 32'd0) begin errors++; $display("FAIL reset_data got r1=%h addr=%h want 0", out_result_1, out_addr); end
        $display("reset: checked outputs while rst_n low");
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        drive(blank());
        q_src = '0;
    endtask

    task automatic test_latency();
        ent_t e;
        e = blank(); e.v = 1; e.t1 = 5'd3; e.r1 = 32'h11;
        q_src = {5'd0, 5'd3};
        drive(e);
        for (int k = 1; k <= D + 1; k++) begin
            tick();
            if (k == 1) drive(blank());
            checks++;
            if (occupancy !== 4'((k <= D) ? 1 : 0)) begin
                errors++; $display("FAIL latency_occ edge %0d got %0d want %0d", k, occupancy, (k <= D) ? 1 : 0);
            end
            checks++;
            if (out_valid !== (k == D)) begin
                errors++; $display("FAIL latency_valid edge %0d got %0b want %0b", k, out_valid, (k == D));
            end
            checks++;
            if (q_hit[0] !== (k <= D) || q_data[31:0] !== ((k <= D) ? 32'h11 : 32'h0)) begin
                errors++; $display("FAIL latency_query edge %0d got hit=%0b data=%h", k, q_hit[0], q_data[31:0]);
            end
            if (k == D) begin
                checks++;
                if (out_result_1 !== 32'h11) begin errors++; $display("FAIL latency_result got %h want 11", out_result_1); end
            end
            $display("latency: edge %0d occ=%0d out_valid=%0b", k, occupancy, out_valid);
        end
    endtask

    task automatic test_forward_priority();
        ent_t a, b, z;
        b = blank(); b.v = 1; b.t1 = 5'd5; b.r1 = 32'hB;
        z = blank(); z.v = 1; z.t1 = 5'd0; z.t2 = 5'd9; z.r1 = 32'h55; z.r2 = 32'h66;
        a = blank(); a.v = 1; a.t1 = 5'd5; a.r1 = 32'hA;
        drive(b); tick();
        drive(z); tick();
        drive(a); tick();
        drive(blank());
        q_src = {5'd0, 5'd5};
        #1;
        checks++;
        if (q_hit[0] !== 1'b1 || q_data[31:0] !== 32'hA || q_load_pend[0] !== 1'b0) begin
            errors++; $display("FAIL fwd_youngest got hit=%0b data=%h pend=%0b want 1/a/0", q_hit[0], q_data[31:0], q_load_pend[0]);
        end
        checks++;
        if (q_hit[1] !== 1'b0 || q_data[63:32] !== 32'h0) begin
            errors++; $display("FAIL fwd_r0 got hit=%0b data=%h want 0/0", q_hit[1], q_data[63:32]);
        end
        q_src = {5'd9, 5'd5};
        #1;
        checks++;
        if (q_hit[1] !== 1'b1 || q_data[63:32] !== 32'h66) begin
            errors++; $display("FAIL fwd_tgt2 got hit=%0b data=%h want 1/66", q_hit[1], q_data[63:32]);
        end
        $display("forward: q0 hit=%0b data=%h q1 hit=%0b data=%h", q_hit[0], q_data[31:0], q_hit[1], q_data[63:32]);
    endtask

    task automatic test_load_pend();
        ent_t l, y;
        l = blank(); l.v = 1; l.ld = 1; l.t1 = 5'd12; l.t2 = 5'd7; l.r1 = 32'h70; l.r2 = 32'h77;
        y = blank(); y.v = 1; y.t1 = 5'd1; y.t2 = 5'd2;
        drive(l); tick();
        drive(y); tick();
        drive(blank());
        q_src = {5'd12, 5'd7};
        #1;
        checks++;
        if (q_hit[0] !== 1'b1 || q_load_pend[0] !== 1'b1 || q_data[31:0] !== 32'h77) begin
            errors++; $display("FAIL load_pend_t2 got hit=%0b pend=%0b data=%h want 1/1/77", q_hit[0], q_load_pend[0], q_data[31:0]);
        end
        checks++;
        if (q_hit[1] !== 1'b1 || q_load_pend[1] !== 1'b1 || q_data[63:32] !== 32'h70) begin
            errors++; $display("FAIL load_pend_t1 got hit=%0b pend=%0b data=%h want 1/1/70", q_hit[1], q_load_pend[1], q_data[63:32]);
        end
        $display("load_pend: q0 pend=%0b data=%h", q_load_pend[0], q_data[31:0]);
    endtask

    task automatic test_random();
        bit h, p;
        bit [31:0] d;
        int bad;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 4) == 0);
            drive(rand_ent(1'($urandom_range(0, 3) != 0)));
            q_src = {5'($urandom_range(0, 7)), 5'($urandom_range(0, 7))};
            tick();
            checks++;
            if (out_valid !== pq[D-1].v || out_opcode !== pq[D-1].op || out_tgt_1 !== pq[D-1].t1 ||
                out_tgt_2 !== pq[D-1].t2 || out_result_1 !== pq[D-1].r1 || out_result_2 !== pq[D-1].r2 ||
                out_addr !== pq[D-1].addr || out_is_load !== pq[D-1].ld || out_is_store !== pq[D-1].st) begin
                errors++; $display("FAIL rand_out cyc %0d got v=%0b r1=%h want v=%0b r1=%h", n, out_valid, out_result_1, pq[D-1].v, pq[D-1].r1);
            end
            checks++;
            if (occupancy !== 4'(m_occ())) begin
                errors++; $display("FAIL rand_occ cyc %0d got %0d want %0d", n, occupancy, m_occ());
            end
            bad = 0;
            for (int q = 0; q < NQ; q++) begin
                mq(q_src[q*5 +: 5], h, d, p);
                if (q_hit[q] !== h || q_data[q*XL +: XL] !== d || q_load_pend[q] !== p) bad++;
            end
            checks++;
            if (bad != 0) begin
                errors++; $display("FAIL rand_query cyc %0d src=%h got hit=%b data=%h pend=%b", n, q_src, q_hit, q_data, q_load_pend);
            end
            $display("random: cyc %0d stall=%0b occ=%0d out_valid=%0b q_hit=%b", n, stall, occupancy, out_valid, q_hit);
        end
        stall = 1'b0;
    endtask

    task automatic test_stall();
        bit h, p;
        bit [31:0] d;
        do_reset();
        for (int k = 0; k < D; k++) begin drive(rand_ent(1)); tick(); end
        q_src = {5'($urandom_range(1, 7)), 5'($urandom_range(1, 7))};
        for (int k = 0; k < 5 + D; k++) begin
            stall = (k < 5);
            drive(rand_ent(1));
            tick();
            checks++;
            if (out_result_1 !== pq[D-1].r1 || out_tgt_1 !== pq[D-1].t1 || out_valid !== pq[D-1].v) begin
                errors++; $display("FAIL stall_out cyc %0d got r1=%h want %h", k, out_result_1, pq[D-1].r1);
            end
            checks++;
            if (occupancy !== 4'(m_occ())) begin
                errors++; $display("FAIL stall_occ cyc %0d got %0d want %0d", k, occupancy, m_occ());
            end
            mq(q_src[4:0], h, d, p);
            checks++;
            if (q_hit[0] !== h || q_data[31:0] !== d || q_load_pend[0] !== p) begin
                errors++; $display("FAIL stall_query cyc %0d got hit=%0b data=%h want %0b/%h", k, q_hit[0], q_data[31:0], h, d);
            end
            $display("stall: cyc %0d stall=%0b out_r1=%h occ=%0d", k, stall, out_result_1, occupancy);
        end
        stall = 1'b0;
    endtask

    task automatic test_halt_and_async_reset();
        ent_t hh, e;
        do_reset();
        hh = blank(); hh.v = 1; hh.hl = 1; hh.t1 = 5'd4; hh.r1 = 32'hDEAD;
        drive(hh); tick();
        for (int k = 2; k <= D; k++) begin drive(rand_ent(1)); tick(); end
        checks++;
        if (out_halt !== 1'b1 || occupancy !== 4'd4) begin
            errors++; $display("FAIL halt_arrive got halt=%0b occ=%0d want 1/4", out_halt, occupancy);
        end
        stall = 1'b1;
        for (int k = 0; k < 2; k++) begin
            drive(rand_ent(1)); tick();
            checks++;
            if (out_halt !== 1'b1 || occupancy !== 4'd4) begin
                errors++; $display("FAIL halt_stall_prio got halt=%0b occ=%0d want 1/4", out_halt, occupancy);
            end
        end
        stall = 1'b0;
        tick();
        checks++;
        if (out_halt !== 1'b1 || occupancy !== 4'd1 || out_result_1 !== 32'hDEAD) begin
            errors++; $display("FAIL halt_kill got halt=%0b occ=%0d r1=%h want 1/1/dead", out_halt, occupancy, out_result_1);
        end
        for (int k = 0; k < 10; k++) begin
            stall = 1'($urandom_range(0, 1));
            drive(rand_ent(1));
            tick();
            checks++;
            if (out_halt !== 1'b1 || occupancy !== 4'd1 || out_result_1 !== 32'hDEAD) begin
                errors++; $display("FAIL halt_frozen cyc %0d got halt=%0b occ=%0d r1=%h", k, out_halt, occupancy, out_result_1);
            end
            $display("halt: frozen cyc %0d occ=%0d out_halt=%0b", k, occupancy, out_halt);
        end
        stall = 1'b0;
        q_src = {5'd0, 5'd4};
        #1;
        checks++;
        if (q_hit[0] !== 1'b1 || q_data[31:0] !== 32'hDEAD) begin
            errors++; $display("FAIL halt_query got hit=%0b data=%h want 1/dead", q_hit[0], q_data[31:0]);
        end
        @(negedge clk);
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (out_valid !== 1'b0 || out_halt !== 1'b0 || occupancy !== 4'd0 || q_hit !== 2'b00) begin
            errors++; $display("FAIL async_reset got v=%0b halt=%0b occ=%0d hit=%b want 0", out_valid, out_halt, occupancy, q_hit);
        end
        @(negedge clk);
        rst_n = 1'b1;
        e = blank(); e.v = 1; e.t1 = 5'd3; e.r1 = 32'h22;
        drive(e);
        tick();
        drive(blank());
        checks++;
        if (occupancy !== 4'd1) begin errors++; $display("FAIL post_reset_load got occ=%0d want 1", occupancy); end
        repeat (D - 1) tick();
        checks++;
        if (out_valid !== 1'b1 || out_result_1 !== 32'h22 || out_halt !== 1'b0) begin
            errors++; $display("FAIL post_reset_flow got v=%0b r1=%h halt=%0b want 1/22/0", out_valid, out_result_1, out_halt);
        end
        $display("async_reset: flow restored out_valid=%0b out_r1=%h", out_valid, out_result_1);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_latency();
        test_forward_priority();
        test_load_pend();
        test_random();
        test_stall();
        test_halt_and_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
